// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: synchronises the host pins, deserialises a fixed
// frame into per-byte output registers with strobes, and serialises a readback word.
module spi_frame_rx #(
    parameter int NBYTES      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              CS,
    output logic              MISO,
    output logic [7:0]        OUT0,
    output logic [7:0]        OUT1,
    output logic [7:0]        OUT2,
    output logic [7:0]        OUT3,
    output logic [7:0]        OUT4,
    output logic [7:0]        OUT5,
    output logic [NBYTES-1:0] OUTSTROBE,
    input  logic [31:0]       IN
);
    localparam int BW = $clog2(NBYTES + 1);
    localparam logic [BW-1:0] NB = BW'(NBYTES);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
    logic sclk_h, cs_h;
    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [7:0]    shift;
    logic          done_pend;
    logic [7:0]    done_byte;
    logic [7:0]    out_r [NBYTES];
    logic [31:0]   tx_reg;
    logic [4:0]    tx_cnt;
    logic          tx_armed, tx_active, miso_pre;

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_h & sclk_s;
    assign sclk_fall = sclk_h & ~sclk_s;
    assign cs_fall   = cs_h & ~cs_s;

    // Equal depth on all three pins keeps MOSI aligned with the SCLK edge it belongs to.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            cs_sr   <= '0;
            sclk_h  <= 1'b0;
            cs_h    <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], CS};
            sclk_h  <= sclk_s;
            cs_h    <= cs_s;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            done_pend <= 1'b0;
            done_byte <= '0;
            for (int i = 0; i < NBYTES; i++) out_r[i] <= '0;
            OUTSTROBE <= '0;
            tx_reg    <= '0;
            tx_cnt    <= '0;
            tx_armed  <= 1'b0;
            tx_active <= 1'b0;
            miso_pre  <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            OUTSTROBE <= '0;
            MISO      <= miso_pre;

            // Completed byte is published one cycle after the shift; saturates at NBYTES.
            if (done_pend) begin
                done_pend <= 1'b0;
                if (byte_cnt < NB) begin
                    out_r[byte_cnt]     <= done_byte;
                    OUTSTROBE[byte_cnt] <= 1'b1;
                    byte_cnt            <= byte_cnt + 1'b1;
                    if (byte_cnt == BW'(1)) tx_armed <= 1'b1;
                end
            end

            case (state)
                WAIT_IDLE: if (cs_s) state <= IDLE;
                IDLE: begin
                    miso_pre  <= 1'b0;
                    tx_armed  <= 1'b0;
                    tx_active <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        shift    <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state    <= IDLE;
                        miso_pre <= 1'b0;
                    end else if (sclk_rise) begin
                        shift   <= {shift[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            done_pend <= 1'b1;
                            done_byte <= {shift[6:0], mosi_s};
                        end
                    end else if (sclk_fall) begin
                        if (tx_active) begin
                            if (tx_cnt == 5'd31) begin
                                tx_active <= 1'b0;
                                miso_pre  <= 1'b0;
                            end else begin
                                tx_reg   <= {tx_reg[30:0], 1'b0};
                                miso_pre <= tx_reg[30];
                                tx_cnt   <= tx_cnt + 5'd1;
                            end
                        end else if (tx_armed) begin
                            tx_reg    <= IN;
                            miso_pre  <= IN[31];
                            tx_cnt    <= '0;
                            tx_active <= 1'b1;
                            tx_armed  <= 1'b0;
                        end
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign OUT0 = out_r[0];
    assign OUT1 = out_r[1];
    assign OUT2 = out_r[2];
    assign OUT3 = out_r[3];
    assign OUT4 = out_r[4];
    assign OUT5 = out_r[5];
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a mode-0 host model at Clk = 8x SCLK,
// a strobe monitor and hand-computed expected bytes.
module tb_spi_frame_rx;
    logic        Clk, Rst, SCLK, MOSI, CS, MISO;
    logic [7:0]  OUT0, OUT1, OUT2, OUT3, OUT4, OUT5;
    logic [5:0]  OUTSTROBE;
    logic [31:0] IN;

    spi_frame_rx #(.NBYTES(6), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Rst(Rst), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
        .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3), .OUT4(OUT4), .OUT5(OUT5),
        .OUTSTROBE(OUTSTROBE), .IN(IN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int rise8 = 0;
    int stb_cnt [6];
    int stb_cyc [6];
    int rise_cyc [8];
    logic [7:0] txb [8];
    logic [7:0] rxb [8];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge Clk) begin
        if (!Rst && OUTSTROBE != 6'd0) begin
            chk("onehot", $countones(OUTSTROBE), 1);
            for (int k = 0; k < 6; k++)
                if (OUTSTROBE[k]) begin
                    stb_cnt[k]++;
                    stb_cyc[k] = cyc;
                end
        end
    end

    task automatic clr_stb();
        for (int k = 0; k < 6; k++) begin
            stb_cnt[k] = 0;
            stb_cyc[k] = 0;
        end
    endtask

    function automatic int stb_total();
        int s = 0;
        for (int k = 0; k < 6; k++) s += stb_cnt[k];
        return s;
    endfunction

    // Host: data changes with the falling edge, MISO sampled just before the rising edge.
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = d[7-i];
            repeat (4) @(negedge Clk);
            rx = {rx[6:0], MISO};
            SCLK = 1'b1;
            if (i == 7) rise8 = cyc;
            repeat (4) @(negedge Clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        logic [7:0] r;
        CS = 1'b0;
        repeat (4) @(negedge Clk);
        for (int b = 0; b < n; b++) begin
            spi_bits(txb[b], 8, r);
            rxb[b]      = r;
            rise_cyc[b] = rise8;
        end
        repeat (8) @(negedge Clk);
        CS = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        Rst = 1'b1; SCLK = 1'b0; MOSI = 1'b0; CS = 1'b1; IN = 32'h0;
        clr_stb();
        repeat (4) @(negedge Clk);
        chk("rst_out0", OUT0, 8'h00);
        chk("rst_out5", OUT5, 8'h00);
        chk("rst_stb", OUTSTROBE, 6'h00);
        chk("rst_miso", MISO, 1'b0);
        Rst = 1'b0;
        repeat (10) @(negedge Clk);

        // Write frame; IN still appears on MISO in bytes 2..5
        IN = 32'hCAFEF00D;
        clr_stb();
        txb = '{8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
        run_frame(6);
        chk("wr_out0", OUT0, 8'h01);
        chk("wr_out1", OUT1, 8'h05);
        chk("wr_out2", OUT2, 8'hDE);
        chk("wr_out3", OUT3, 8'hAD);
        chk("wr_out4", OUT4, 8'hBE);
        chk("wr_out5", OUT5, 8'hEF);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("wr_stbcnt%0d", k), stb_cnt[k], 1);
            chk($sformatf("wr_lat%0d", k), stb_cyc[k] - rise_cyc[k], 4);
        end
        chk("wr_miso0", rxb[0], 8'h00);
        chk("wr_miso1", rxb[1], 8'h00);
        chk("wr_miso2", rxb[2], 8'hCA);
        chk("wr_miso5", rxb[5], 8'h0D);

        // Read frame
        IN = 32'h12345678;
        clr_stb();
        txb = '{8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(6);
        chk("rd_miso0", rxb[0], 8'h00);
        chk("rd_miso1", rxb[1], 8'h00);
        chk("rd_miso2", rxb[2], 8'h12);
        chk("rd_miso3", rxb[3], 8'h34);
        chk("rd_miso4", rxb[4], 8'h56);
        chk("rd_miso5", rxb[5], 8'h78);
        chk("rd_out1", OUT1, 8'h04);
        chk("rd_stbs", stb_total(), 6);

        // Abort after 13 bits
        clr_stb();
        CS = 1'b0;
        repeat (4) @(negedge Clk);
        spi_bits(8'h02, 8, r);
        spi_bits(8'hFF, 5, r);
        repeat (8) @(negedge Clk);
        CS = 1'b1;
        repeat (8) @(negedge Clk);
        chk("ab_out0", OUT0, 8'h02);
        chk("ab_out1", OUT1, 8'h04);
        chk("ab_stb0", stb_cnt[0], 1);
        chk("ab_stbs", stb_total(), 1);
        chk("ab_miso_idle", MISO, 1'b0);
        clr_stb();
        txb = '{8'h03, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00};
        run_frame(6);
        chk("ab2_out0", OUT0, 8'h03);
        chk("ab2_out1", OUT1, 8'h01);
        chk("ab2_out2", OUT2, 8'hAA);
        chk("ab2_out5", OUT5, 8'hDD);

        // Overrun: 8 bytes in one frame
        IN = 32'hA1B2C3D4;
        clr_stb();
        txb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame(8);
        chk("ov_stbs", stb_total(), 6);
        chk("ov_out0", OUT0, 8'h01);
        chk("ov_out5", OUT5, 8'h06);
        chk("ov_miso5", rxb[5], 8'hD4);
        chk("ov_miso6", rxb[6], 8'h00);
        chk("ov_miso7", rxb[7], 8'h00);

        // Reset during byte 2 with CS held low
        clr_stb();
        CS = 1'b0;
        repeat (4) @(negedge Clk);
        spi_bits(8'h11, 8, r);
        spi_bits(8'h22, 8, r);
        spi_bits(8'h33, 3, r);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("mr_out0", OUT0, 8'h00);
        chk("mr_out5", OUT5, 8'h00);
        chk("mr_miso", MISO, 1'b0);
        clr_stb();
        spi_bits(8'h98, 5, r);
        spi_bits(8'h44, 8, r);
        chk("mr_miso3", r, 8'h00);
        spi_bits(8'h55, 8, r);
        chk("mr_miso4", r, 8'h00);
        spi_bits(8'h66, 8, r);
        chk("mr_miso5", r, 8'h00);
        repeat (8) @(negedge Clk);
        chk("mr_stbs", stb_total(), 0);
        chk("mr_out1", OUT1, 8'h00);
        CS = 1'b1;
        repeat (8) @(negedge Clk);
        txb = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(6);
        chk("mr2_out0", OUT0, 8'h04);
        chk("mr2_out1", OUT1, 8'h01);

        // 8th SCLK rise and CS rise land in the same cycle
        clr_stb();
        CS = 1'b0;
        repeat (4) @(negedge Clk);
        spi_bits(8'h5A, 7, r);
        MOSI = 1'b0;
        repeat (4) @(negedge Clk);
        SCLK = 1'b1;
        CS = 1'b1;
        repeat (4) @(negedge Clk);
        SCLK = 1'b0;
        repeat (10) @(negedge Clk);
        chk("sim_stbs", stb_total(), 0);
        chk("sim_out0", OUT0, 8'h04);
        txb = '{8'h77, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(6);
        chk("sim2_out0", OUT0, 8'h77);
        chk("sim2_stb0", stb_cnt[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
